// File: rtl/fpu_addsub_sequencer.sv
// fpu_addsub_sequencer
//   Registered front/back end for a combinational double-precision add/sub
//   datapath. One operation is accepted over a valid/ready handshake. Its
//   operands are held stable on the adder inputs for SETTLE_CYCLES clocks, so
//   the adder can be timed as a multicycle path. Result/Exception are then
//   captured and offered on an output valid/ready handshake. A saturating
//   counter tracks how many captured results carried an exception.
module fpu_addsub_sequencer #(
  parameter int SETTLE_CYCLES = 2,   // legal range 1..15
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,

  // Issue side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic             in_op,

  // Adder side: these outputs drive the adder, Result/Exception come back from it
  output logic             enable,
  output logic [63:0]      a_operand,
  output logic [63:0]      b_operand,
  output logic             Add_or_Sub,
  input  logic [63:0]      Result,
  input  logic             Exception,

  // Result side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic             out_exception,

  // Status
  output logic             busy,
  output logic [CNT_W-1:0] exc_count
);

  // NOTE: cnt is sized to hold SETTLE_CYCLES itself, so the load value
  // SETTLE_CYCLES-1 always fits, even when SETTLE_CYCLES is a power of two.
  localparam int CNT_BITS = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(SETTLE_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_W-1:0]    EXC_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_BITS-1:0] cnt;

  // Single registered FSM: accept, settle, capture, then hold until taken.
  // NOTE: every register here uses non-blocking assignment so all of them
  // update together on the edge and read each other's pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      in_ready      <= 1'b1;
      busy          <= 1'b0;
      enable        <= 1'b0;
      a_operand     <= '0;
      b_operand     <= '0;
      Add_or_Sub    <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_exception <= 1'b0;
      exc_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Operands change only here; they are left untouched in HOLD
            // and IDLE so the adder inputs never glitch between operations.
            a_operand  <= in_a;
            b_operand  <= in_b;
            Add_or_Sub <= in_op;
            cnt        <= CNT_LOAD;
            enable     <= 1'b1;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= SETTLE;
          end
        end

        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            // The adder has had SETTLE_CYCLES clocks: sample it exactly once.
            out_result    <= Result;
            out_exception <= Exception;
            out_valid     <= 1'b1;
            enable        <= 1'b0;
            state         <= HOLD;
            if (Exception && !(&exc_count)) begin
              exc_count <= exc_count + EXC_ONE;
            end
          end
        end

        HOLD: begin
          // in_ready stays low on the handshake edge, so a new op can be
          // taken no earlier than the following edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          enable   <= 1'b0;
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
